mem_req_arbiter: RTL

// - N-channel arbiter that funnels CPU memory requests (inst fetch, load/store, later uncached/TLB-walk ports)

---
 rtl/mem_req_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// ---------------------------------------------------------------------------
// Funnels up to eight CPU memory requesters (channel 0 = instruction fetch,
// then load/store, uncached, TLB walk ...) onto the single mem_* request port
// of the AXI interface. The winning request is registered and held stable
// until mem_ready. Completion is returned as a one-cycle ch_ready pulse on the
// owning channel, and an exception flush cancels flushable channels in flight.
//
// Parameters
//   N_CH      number of requesting channels (2..8)
//   ARB_MODE  0 = round-robin, 1 = fixed priority (lowest index wins)
//   FLUSH_MSK bit i set: channel i is cancelled by flush
//   CH_W      width of grant_id
//
// Ports
//   clk, resetn            core clock; resetn is a synchronous ACTIVE-HIGH reset
//   req_access/write/size/sel/addr/wdata   per-channel request buses (packed)
//   ch_ready, ch_stall     per-channel completion pulse / stall
//   ch_rdata               read data (always mem_data)
//   grant_id               channel currently owning the mem port
//   mem_access/write/size/sel/a/st_data    registered request to axi_interface
//   mem_ready, mem_data    transfer complete / read data from axi_interface
//   flush, mem_flush       exception flush in, cancel indication out
//
// Build option
//   MEM_ARB_REMAP_EN: addresses with [31:16] == 16'hbfaf are rewritten to
//   16'h1faf when latched (confreg window); otherwise addresses pass unchanged.
// ---------------------------------------------------------------------------
module mem_req_arbiter #(
    parameter int              N_CH      = 2,
    parameter int              ARB_MODE  = 0,
    parameter logic [N_CH-1:0] FLUSH_MSK = 'b10,
    parameter int              CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_CH-1:0]      req_access,
    input  logic [N_CH-1:0]      req_write,
    input  logic [2*N_CH-1:0]    req_size,
    input  logic [4*N_CH-1:0]    req_sel,
    input  logic [32*N_CH-1:0]   req_addr,
    input  logic [32*N_CH-1:0]   req_wdata,
    output logic [N_CH-1:0]      ch_ready,
    output logic [N_CH-1:0]      ch_stall,
    output logic [31:0]          ch_rdata,
    output logic [CH_W-1:0]      grant_id,
    output logic                 mem_access,
    output logic                 mem_write,
    output logic [1:0]           mem_size,
    output logic [3:0]           mem_sel,
    output logic [31:0]          mem_a,
    output logic [31:0]          mem_st_data,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_data,
    input  logic                 flush,
    output logic                 mem_flush
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_reg;
    logic [CH_W-1:0] rr_ptr_reg;
    logic [CH_W-1:0] grant_id_reg;
    logic            mem_access_reg;
    logic            mem_write_reg;
    logic [1:0]      mem_size_reg;
    logic [3:0]      mem_sel_reg;
    logic [31:0]     mem_a_reg;
    logic [31:0]     mem_st_data_reg;

    // Per-channel views of the packed request buses
    logic [1:0]  size_arr  [N_CH];
    logic [3:0]  sel_arr   [N_CH];
    logic [31:0] addr_arr  [N_CH];
    logic [31:0] wdata_arr [N_CH];

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign size_arr[gi]  = req_size[gi*2 +: 2];
        assign sel_arr[gi]   = req_sel[gi*4 +: 4];
        assign addr_arr[gi]  = req_addr[gi*32 +: 32];
        assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
    end

    function automatic logic [31:0] remap_addr(input logic [31:0] a);
`ifdef MEM_ARB_REMAP_EN
        if (a[31:16] == 16'hbfaf) begin
            return {16'h1faf, a[15:0]};
        end
        return a;
`else
        return a;
`endif
    endfunction

    // Winner search: walk the channels starting at the round-robin pointer
    // (or at 0 in fixed-priority mode) and take the first one requesting.
    // The candidate index is kept one bit wider so the wrap is a subtract.
    logic [CH_W-1:0] winner_next;
    logic [CH_W-1:0] base_ptr;
    logic            found;
    logic            any_req;

    assign any_req = |req_access;

    always_comb begin
        logic [CH_W:0] cand;
        cand        = '0;
        base_ptr    = (ARB_MODE == 1) ? '0 : rr_ptr_reg;
        winner_next = '0;
        found       = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            cand = {1'b0, base_ptr} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(N_CH)) begin
                cand = cand - (CH_W+1)'(N_CH);
            end
            if (!found && req_access[cand[CH_W-1:0]]) begin
                found       = 1'b1;
                winner_next = cand[CH_W-1:0];
            end
        end
    end

    logic [CH_W-1:0] rr_ptr_next;
    assign rr_ptr_next = (grant_id_reg == CH_W'(N_CH - 1)) ? '0 : grant_id_reg + CH_W'(1);

    logic busy;
    logic flush_hit;
    assign busy      = (state_reg == BUSY);
    assign flush_hit = flush & busy & FLUSH_MSK[grant_id_reg];

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            grant_id_reg    <= '0;
            mem_access_reg  <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_size_reg    <= '0;
            mem_sel_reg     <= '0;
            mem_a_reg       <= '0;
            mem_st_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_id_reg    <= winner_next;
                        mem_access_reg  <= 1'b1;
                        mem_write_reg   <= req_write[winner_next];
                        mem_size_reg    <= size_arr[winner_next];
                        mem_sel_reg     <= sel_arr[winner_next];
                        mem_a_reg       <= remap_addr(addr_arr[winner_next]);
                        mem_st_data_reg <= wdata_arr[winner_next];
                        state_reg       <= BUSY;
                    end
                end
                BUSY: begin
                    // mem_ready takes precedence over a simultaneous flush so
                    // a transfer the bus already finished is never lost.
                    if (mem_ready) begin
                        mem_access_reg <= 1'b0;
                        state_reg      <= IDLE;
                        if (ARB_MODE == 0) begin
                            rr_ptr_reg <= rr_ptr_next;
                        end
                    end else if (flush_hit) begin
                        mem_access_reg <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ch_ready = '0;
        if (busy && mem_ready) begin
            ch_ready[grant_id_reg] = 1'b1;
        end
    end

    assign ch_stall    = req_access & ~ch_ready;
    assign ch_rdata    = mem_data;
    assign grant_id    = grant_id_reg;
    assign mem_access  = mem_access_reg;
    assign mem_write   = mem_write_reg;
    assign mem_size    = mem_size_reg;
    assign mem_sel     = mem_sel_reg;
    assign mem_a       = mem_a_reg;
    assign mem_st_data = mem_st_data_reg;
    assign mem_flush   = flush_hit;

endmodule
